word_fetch_sequencer: RTL and testbench



---
 rtl/word_fetch_sequencer.sv | 106 ++++++++++
 tb/tb_word_fetch_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/word_fetch_sequencer.sv
// Fetch sequencer: streams WORD_COUNT consecutive memory words into the
// falling-edge load register, one word per TAKE handshake.
module word_fetch_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [CNT_WIDTH-1:0]  WORD_COUNT,
    output logic                  MEM_RD,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    input  logic                  MEM_WAIT,
    input  logic [DATA_WIDTH-1:0] MEM_DATA,
    output logic                  LOAD_EN,
    output logic [DATA_WIDTH-1:0] LOAD_DATA,
    input  logic                  TAKE,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_PRESENT = 2'd3;

    // RD_LATENCY is at most 4, so the down-counter never exceeds 3.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [1:0]            lat_cnt;

    // Every output is a flop, so the downstream register always samples a
    // value that settled half a cycle earlier.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            MEM_RD    <= 1'b0;
            MEM_ADDR  <= '0;
            LOAD_EN   <= 1'b0;
            LOAD_DATA <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        if (WORD_COUNT != '0) begin
                            addr      <= BASE_ADDR;
                            remaining <= WORD_COUNT;
                            MEM_RD    <= 1'b1;
                            MEM_ADDR  <= BASE_ADDR;
                            BUSY      <= 1'b1;
                            state     <= S_ISSUE;
                        end else begin
                            DONE <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!MEM_WAIT) begin
                        MEM_RD  <= 1'b0;
                        lat_cnt <= LAT_LOAD;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        LOAD_DATA <= MEM_DATA;
                        LOAD_EN   <= 1'b1;
                        state     <= S_PRESENT;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_PRESENT: begin
                    if (TAKE) begin
                        LOAD_EN   <= 1'b0;
                        remaining <= remaining - CNT_WIDTH'(1);
                        addr      <= addr + ADDR_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) begin
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            MEM_RD   <= 1'b1;
                            MEM_ADDR <= addr + ADDR_WIDTH'(1);
                            state    <= S_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_fetch_sequencer.sv
// Directed bench for word_fetch_sequencer: one instance at read latency 1,
// one at read latency 3, each fed by its own pipelined memory model.
module tb_word_fetch_sequencer;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [15:0] BASE_ADDR;
    logic [7:0]  WORD_COUNT;
    logic        MEM_WAIT;
    logic        TAKE;

    logic        mem_rd1, mem_rd3;
    logic [15:0] mem_addr1, mem_addr3;
    logic [31:0] mem_data1, mem_data3;
    logic        load_en1, load_en3;
    logic [31:0] load_data1, load_data3;
    logic        busy1, busy3;
    logic        done1, done3;

    int checks = 0;
    int errors = 0;

    word_fetch_sequencer #(.RD_LATENCY(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR),
        .WORD_COUNT(WORD_COUNT), .MEM_RD(mem_rd1), .MEM_ADDR(mem_addr1),
        .MEM_WAIT(MEM_WAIT), .MEM_DATA(mem_data1), .LOAD_EN(load_en1),
        .LOAD_DATA(load_data1), .TAKE(TAKE), .BUSY(busy1), .DONE(done1)
    );

    word_fetch_sequencer #(.RD_LATENCY(3)) dut3 (
        .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR),
        .WORD_COUNT(WORD_COUNT), .MEM_RD(mem_rd3), .MEM_ADDR(mem_addr3),
        .MEM_WAIT(MEM_WAIT), .MEM_DATA(mem_data3), .LOAD_EN(load_en3),
        .LOAD_DATA(load_data3), .TAKE(TAKE), .BUSY(busy3), .DONE(done3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {16'd0, a} * 32'h0101_0101;
    endfunction

    // Memory model: an accepted address walks down a valid pipeline; data is
    // only meaningful in the cycle the request reaches the latency stage.
    logic [3:0]       vld1, vld3;
    logic [3:0][15:0] ad1, ad3;

    always @(posedge CLK) begin
        if (RST) begin
            vld1 <= '0;
            vld3 <= '0;
        end else begin
            vld1 <= {vld1[2:0], mem_rd1 && !MEM_WAIT};
            vld3 <= {vld3[2:0], mem_rd3 && !MEM_WAIT};
        end
        ad1 <= {ad1[2:0], mem_addr1};
        ad3 <= {ad3[2:0], mem_addr3};
    end

    assign mem_data1 = vld1[0] ? word_of(ad1[0]) : 32'hDEAD_BEEF;
    assign mem_data3 = vld3[2] ? word_of(ad3[2]) : 32'hDEAD_BEEF;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic apply_stimulus(input logic start, input logic [15:0] base,
                                  input logic [7:0] count);
        START      = start;
        BASE_ADDR  = base;
        WORD_COUNT = count;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        START = 1'b0;
        while ((busy1 || busy3) && n < 60) begin
            tick();
            n++;
        end
        check_output("idle_timeout", 32'(busy1 | busy3), 32'd0);
        tick();
    endtask

    logic [31:0] burst_exp [3] = '{32'h1010_1010, 32'h1111_1111, 32'h1212_1212};
    logic [15:0] wrap_exp  [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

    initial begin
        RST = 1'b1;
        MEM_WAIT = 1'b0;
        TAKE = 1'b0;
        apply_stimulus(1'b0, 16'h0000, 8'd0);
        tick();
        tick();
        RST = 1'b0;
        check_output("reset_outputs1",
            32'({mem_rd1, mem_addr1, load_en1, busy1, done1}), 32'd0);
        check_output("reset_data1", load_data1, 32'd0);
        check_output("reset_outputs3",
            32'({mem_rd3, mem_addr3, load_en3, busy3, done3}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("idle_quiet", 32'({mem_rd1, load_en1, busy1, done1}), 32'd0);
        end

        $display("[TB] basic burst");
        TAKE = 1'b1;
        apply_stimulus(1'b1, 16'h0010, 8'd3);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0);
        for (int w = 0; w < 3; w++) begin
            check_output("burst_rd", 32'(mem_rd1), 32'd1);
            check_output("burst_addr", 32'(mem_addr1), 32'(16'h0010 + 16'(w)));
            check_output("burst_busy", 32'(busy1), 32'd1);
            check_output("burst_en_early", 32'(load_en1), 32'd0);
            tick();
            check_output("burst_wait", 32'({mem_rd1, load_en1}), 32'd0);
            tick();
            check_output("burst_en", 32'(load_en1), 32'd1);
            check_output("burst_data", load_data1, burst_exp[w]);
            check_output("burst_done_low", 32'(done1), 32'd0);
            tick();
        end
        check_output("burst_done", 32'(done1), 32'd1);
        check_output("burst_busy_drop", 32'(busy1), 32'd0);
        check_output("burst_en_drop", 32'(load_en1), 32'd0);
        check_output("burst_data_hold", load_data1, 32'h1212_1212);
        tick();
        check_output("burst_done_pulse", 32'(done1), 32'd0);
        wait_idle();

        $display("[TB] stalls");
        TAKE = 1'b0;
        apply_stimulus(1'b1, 16'h0020, 8'd2);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0);
        check_output("stall_rd0", 32'({mem_rd1, mem_addr1}), 32'h0001_0020);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            check_output("stall_take_en", 32'(load_en1), 32'd1);
            check_output("stall_take_data", load_data1, 32'h2020_2020);
            if (i < 5) tick();
        end
        TAKE = 1'b1;
        MEM_WAIT = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("stall_wait_rd", 32'({mem_rd1, mem_addr1}), 32'h0001_0021);
            check_output("stall_wait_en", 32'(load_en1), 32'd0);
        end
        MEM_WAIT = 1'b0;
        tick();
        check_output("stall_accept", 32'({mem_rd1, load_en1}), 32'd0);
        tick();
        check_output("stall_word1_en", 32'(load_en1), 32'd1);
        check_output("stall_word1_data", load_data1, 32'h2121_2121);
        tick();
        check_output("stall_done", 32'({done1, busy1}), 32'd2);
        wait_idle();

        $display("[TB] boundaries");
        apply_stimulus(1'b1, 16'h0077, 8'd0);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0);
        check_output("zero_done", 32'({done1, busy1, mem_rd1}), 32'd4);
        check_output("zero_done3", 32'({done3, busy3, mem_rd3}), 32'd4);
        tick();
        check_output("zero_after", 32'({done1, busy1, mem_rd1}), 32'd0);

        apply_stimulus(1'b1, 16'hFFFE, 8'd3);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0);
        for (int w = 0; w < 3; w++) begin
            check_output("wrap_addr", 32'({mem_rd1, mem_addr1}), {15'd0, 1'b1, wrap_exp[w]});
            tick();
            if (w == 0) apply_stimulus(1'b1, 16'h1234, 8'd5);
            tick();
            apply_stimulus(1'b0, 16'h0000, 8'd0);
            check_output("wrap_data", load_data1, word_of(wrap_exp[w]));
            tick();
        end
        check_output("wrap_done", 32'({done1, busy1}), 32'd2);
        tick();
        check_output("ignored_start", 32'({busy1, mem_rd1}), 32'd0);
        wait_idle();

        $display("[TB] reset mid-operation");
        TAKE = 1'b0;
        apply_stimulus(1'b1, 16'h0030, 8'd2);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0);
        tick();
        tick();
        check_output("pre_reset_en", 32'(load_en1), 32'd1);
        RST = 1'b1;
        tick();
        check_output("midreset_outputs1",
            32'({mem_rd1, mem_addr1, load_en1, busy1, done1}), 32'd0);
        check_output("midreset_data1", load_data1, 32'd0);
        check_output("midreset_outputs3",
            32'({mem_rd3, mem_addr3, load_en3, busy3, done3}), 32'd0);
        RST = 1'b0;
        TAKE = 1'b1;
        apply_stimulus(1'b1, 16'h0040, 8'd1);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0);
        check_output("restart_rd", 32'({mem_rd1, mem_addr1}), 32'h0001_0040);
        tick();
        tick();
        check_output("restart_data", 32'({31'd0, load_en1}), 32'd1);
        check_output("restart_word", load_data1, 32'h4040_4040);
        tick();
        check_output("restart_done", 32'({done1, busy1}), 32'd2);
        wait_idle();

        $display("[TB] latency sweep");
        apply_stimulus(1'b1, 16'h0050, 8'd2);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0);
        check_output("lat3_rd0", 32'({mem_rd3, mem_addr3}), 32'h0001_0050);
        tick();
        tick();
        tick();
        check_output("lat3_en_early", 32'(load_en3), 32'd0);
        tick();
        check_output("lat3_en0", 32'(load_en3), 32'd1);
        check_output("lat3_data0", load_data3, 32'h5050_5050);
        tick();
        check_output("lat3_rd1", 32'({mem_rd3, mem_addr3}), 32'h0001_0051);
        tick();
        tick();
        tick();
        check_output("lat3_en1_early", 32'(load_en3), 32'd0);
        tick();
        check_output("lat3_en1", 32'(load_en3), 32'd1);
        check_output("lat3_data1", load_data3, 32'h5151_5151);
        tick();
        check_output("lat3_done", 32'({done3, busy3}), 32'd2);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
